fire_alarm_controller: RTL and testbench
========================================

# fire_alarm_controller

Supervisory sequencer that sits downstream of the per-zone detector combiner. It confirms zone alarms over consecutive cycles, latches confirmed zones, and drives the sounder. It handles operator acknowledge/silence and clear, and escalates to the fire-service call line on heat or on an unacknowledged alarm timeout.

## Interface
- CONFIRM_CYCLES, 4: consecutive high cycles needed on a zone before it latches (≥1)
- DISPATCH_DELAY, 16: cycles spent in ALARM without ack before call escalates (≥1)
- SILENCE_CYCLES, 32: cycles the sounder stays silenced after ack before resounding (≥1)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- zone_in  in  4  per-zone alarm request (smoke OR heat per zone)
- heat_in  in  1  any-zone heat call request
- ack  in  1  operator acknowledge, single-cycle pulse
- clear  in  1  operator clear, single-cycle pulse
- sounder  out  1  alarm sounder drive
- call  out  1  fire-service dispatch line
- zone_latched  out  4  confirmed zones, sticky until cleared
- state  out  2  FSM state encoding: IDLE=0, ALARM=1, ACKED=2, DISPATCH=3

## Operation
- Per-zone confirm counter:
  - Increments while zone_in[i]=1 and saturates at CONFIRM_CYCLES.
  - Resets to 0 on any cycle with zone_in[i]=0.
  - zone_latched[i] sets on the edge where the counter reaches CONFIRM_CYCLES.
- zone_latched bits clear only on an accepted clear.
- All outputs are registered; sounder and call decode from the registered state (Moore).
- IDLE: sounder=0, call=0. Leaves for ALARM on the edge after any zone_latched bit is 1.
- ALARM: sounder=1. Dispatch timer is cleared on entry and increments each cycle. Exits:
  - heat_in=1 -> DISPATCH.
  - Timer reaches DISPATCH_DELAY -> DISPATCH.
  - Otherwise ack=1 -> ACKED.
- ACKED: sounder=0, call=0. Silence timer is cleared on entry. zone_latched is snapshotted on entry. Exits, in priority order:
  - heat_in=1 -> DISPATCH.
  - A zone latches that is not in the snapshot -> ALARM.
  - Silence timer reaches SILENCE_CYCLES -> ALARM.
  - clear=1 with zone_in=0 -> IDLE, and all zone_latched clear.
- DISPATCH: sounder=1, call=1. ack is ignored. clear=1 with zone_in=0 and heat_in=0 -> IDLE, and zone_latched clears.
- clear is ignored in IDLE and ALARM. It is also ignored while any zone_in is high.
- Simultaneous events:
  - heat_in beats ack.
  - A new confirmation beats clear, and the new bit survives.
  - Dispatch timeout beats ack.
- Reset mid-operation: outputs drop to 0 asynchronously, all counters clear, and state=IDLE.

## Timing
- Reset values: sounder=0, call=0, zone_latched=0, state=IDLE (0).
- zone_in rise at edge 0, held high: zone_latched rises after edge CONFIRM_CYCLES, and sounder rises one edge later.
- Unacknowledged ALARM: call rises DISPATCH_DELAY+1 edges after ALARM entry.
- heat_in in ALARM or ACKED: call rises on the next edge.
- ack is sampled on an edge and sounder falls on that edge. Resound happens SILENCE_CYCLES+1 edges after ACKED entry.
- All transitions take exactly one edge; there are no multi-cycle handshakes.

## Configuration
- FIRE_ALARM_WALK_TEST_EN defined:
  - Adds input walk_test (1 bit).
  - While walk_test=1 and state=IDLE, confirmed zones latch but the FSM stays in IDLE.
  - sounder pulses high for exactly one cycle per newly latched zone; call never asserts.
  - clear is accepted in IDLE.
  - walk_test is ignored in all other states.
- Undefined: walk_test port absent; behaviour exactly as above.

## Test plan
- Reset mid-alarm: zone_in=4'b0010 held 10 cycles, then reset pulsed -> zone_latched=0, sounder=0, call=0, state=0 while reset is high.
- Glitch rejection: zone_in[0] high 3 cycles, low 1, high 3 (defaults) -> zone_latched stays 0, state stays IDLE.
- Escalation: zone_in=4'b0001 held, no ack -> zone_latched=1 after edge 4, sounder=1 after edge 5, call=1 after edge 22, state=3.
- Ack, resound and clear: zone_in[2] confirmed, ack 3 cycles into ALARM -> sounder=0, state=2, resound after 33 edges. A second ack, then zone_in=0 plus clear -> state=0, zone_latched=0.
- New zone during silence: zone 0 latched and acked, then zone_in[3] held 4 cycles -> state=1, sounder=1, zone_latched=4'b1001.
- Priority: in ALARM, ack and heat_in asserted the same cycle -> state=3, call=1 next edge. clear with zone_in≠0 in DISPATCH -> ignored.

Source files
------------

// File: rtl/fire_alarm_controller.sv
// Supervisory fire-alarm sequencer: zone confirmation, latching, sounder/call control.
// Optional walk-test mode is enabled by defining FIRE_ALARM_WALK_TEST_EN.
module fire_alarm_controller #(
  parameter int CONFIRM_CYCLES = 4,
  parameter int DISPATCH_DELAY = 16,
  parameter int SILENCE_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] zone_in,
  input  logic       heat_in,
  input  logic       ack,
  input  logic       clear,
`ifdef FIRE_ALARM_WALK_TEST_EN
  input  logic       walk_test,
`endif
  output logic       sounder,
  output logic       call,
  output logic [3:0] zone_latched,
  output logic [1:0] state
);

  localparam int CW = $clog2(CONFIRM_CYCLES + 1);
  localparam int DW = $clog2(DISPATCH_DELAY + 1);
  localparam int SW = $clog2(SILENCE_CYCLES + 1);
  localparam logic [CW-1:0] CONF_MAX  = CW'(CONFIRM_CYCLES);
  localparam logic [CW-1:0] CONF_LAST = CW'(CONFIRM_CYCLES - 1);
  localparam logic [DW-1:0] DLY_MAX   = DW'(DISPATCH_DELAY);
  localparam logic [SW-1:0] SIL_MAX   = SW'(SILENCE_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ALARM    = 2'd1,
    S_ACKED    = 2'd2,
    S_DISPATCH = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q [4];
  logic [CW-1:0]   cnt_d [4];
  logic [3:0]      set_v;
  logic [3:0]      zone_latched_q, zone_latched_d;
  logic [3:0]      snap_q, snap_d;
  logic [DW-1:0]   dly_q, dly_d;
  logic [SW-1:0]   sil_q, sil_d;
  logic            clear_acc;
  logic            walk_hold;
  logic            zone_idle;

  assign zone_idle = (zone_in == 4'b0000);

`ifdef FIRE_ALARM_WALK_TEST_EN
  logic walk_snd_q, walk_snd_d;
  assign walk_hold  = walk_test && (state_q == S_IDLE);
  assign walk_snd_d = walk_hold && (|set_v);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) walk_snd_q <= 1'b0;
    else       walk_snd_q <= walk_snd_d;
  end
`else
  assign walk_hold = 1'b0;
`endif

  // A zone latches on the edge its run of consecutive high samples reaches CONFIRM_CYCLES.
  always_comb begin
    set_v = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (zone_in[i]) begin
        set_v[i] = (cnt_q[i] == CONF_LAST);
        cnt_d[i] = (cnt_q[i] == CONF_MAX) ? CONF_MAX : cnt_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      zone_latched_q <= 4'b0000;
      snap_q         <= 4'b0000;
      dly_q          <= '0;
      sil_q          <= '0;
    end else begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      zone_latched_q <= zone_latched_d;
      snap_q         <= snap_d;
      dly_q          <= dly_d;
      sil_q          <= sil_d;
    end
  end

  // Timers run only in their own state and sit at zero elsewhere, so entry always restarts them.
  always_comb begin
    dly_d = '0;
    if (state_q == S_ALARM) dly_d = (dly_q == DLY_MAX) ? dly_q : dly_q + DW'(1);
    sil_d = '0;
    if (state_q == S_ACKED) sil_d = (sil_q == SIL_MAX) ? sil_q : sil_q + SW'(1);
    snap_d = ((state_q != S_ACKED) && (state_d == S_ACKED)) ? zone_latched_q : snap_q;
    zone_latched_d = (clear_acc ? 4'b0000 : zone_latched_q) | set_v;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    clear_acc = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((|zone_latched_q) && !walk_hold) begin
          state_d = S_ALARM;
        end else if (walk_hold && clear && zone_idle) begin
          clear_acc = 1'b1;
        end
      end
      S_ALARM: begin
        if (heat_in || (dly_q == DLY_MAX)) state_d = S_DISPATCH;
        else if (ack)                      state_d = S_ACKED;
      end
      S_ACKED: begin
        // A bit latched on this edge counts too, so a new confirmation always beats clear.
        if (heat_in) begin
          state_d = S_DISPATCH;
        end else if (|((zone_latched_q | set_v) & ~snap_q)) begin
          state_d = S_ALARM;
        end else if (sil_q == SIL_MAX) begin
          state_d = S_ALARM;
        end else if (clear && zone_idle) begin
          state_d   = S_IDLE;
          clear_acc = 1'b1;
        end
      end
      default: begin
        if (clear && zone_idle && !heat_in) begin
          state_d   = S_IDLE;
          clear_acc = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    sounder = (state_q == S_ALARM) || (state_q == S_DISPATCH);
`ifdef FIRE_ALARM_WALK_TEST_EN
    sounder = sounder || walk_snd_q;
`endif
    call         = (state_q == S_DISPATCH);
    state        = state_q;
    zone_latched = zone_latched_q;
  end

endmodule

// File: tb/tb_fire_alarm_controller.sv
// Scoreboard bench for fire_alarm_controller with default parameters.
module tb_fire_alarm_controller;

  localparam int CC = 4;
  localparam int DD = 16;
  localparam int SC = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] zone_in;
  logic       heat_in, ack, clear;
  logic       sounder, call;
  logic [3:0] zone_latched;
  logic [1:0] state;

  always #5 clk = ~clk;

  fire_alarm_controller #(
    .CONFIRM_CYCLES(CC),
    .DISPATCH_DELAY(DD),
    .SILENCE_CYCLES(SC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .zone_in(zone_in),
    .heat_in(heat_in),
    .ack(ack),
    .clear(clear),
    .sounder(sounder),
    .call(call),
    .zone_latched(zone_latched),
    .state(state)
  );

  typedef struct packed {
    logic [1:0] st;
    logic [3:0] zl;
    logic       snd;
    logic       cl;
  } exp_t;

  exp_t sb_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  int         m_cnt [4];
  int         m_st, m_dly, m_sil;
  logic [3:0] m_zl, m_snap;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_st = 0; m_dly = 0; m_sil = 0; m_zl = 4'b0; m_snap = 4'b0;
  endtask

  // Reference behaviour for one clock edge given the inputs presented before it.
  task automatic model_step(input logic [3:0] z, input logic h, input logic a, input logic c);
    int         nst;
    logic       clr;
    logic [3:0] nset;
    nset = 4'b0;
    for (int i = 0; i < 4; i++) begin
      if (z[i]) begin
        if (m_cnt[i] == CC - 1) nset[i] = 1'b1;
        if (m_cnt[i] < CC) m_cnt[i] = m_cnt[i] + 1;
      end else begin
        m_cnt[i] = 0;
      end
    end
    nst = m_st;
    clr = 1'b0;
    case (m_st)
      0: if (m_zl != 4'b0) nst = 1;
      1: begin
        if (h || m_dly == DD) nst = 3;
        else if (a) nst = 2;
      end
      2: begin
        if (h) nst = 3;
        else if (((m_zl | nset) & ~m_snap) != 4'b0) nst = 1;
        else if (m_sil == SC) nst = 1;
        else if (c && z == 4'b0) begin nst = 0; clr = 1'b1; end
      end
      default: if (c && z == 4'b0 && !h) begin nst = 0; clr = 1'b1; end
    endcase
    m_dly = (m_st == 1) ? ((m_dly < DD) ? m_dly + 1 : m_dly) : 0;
    m_sil = (m_st == 2) ? ((m_sil < SC) ? m_sil + 1 : m_sil) : 0;
    if (m_st != 2 && nst == 2) m_snap = m_zl;
    m_zl = (clr ? 4'b0 : m_zl) | nset;
    m_st = nst;
  endtask

  task automatic cyc(input logic [3:0] z, input logic h, input logic a, input logic c);
    exp_t e;
    zone_in = z; heat_in = h; ack = a; clear = c;
    model_step(z, h, a, c);
    e.st  = 2'(m_st);
    e.zl  = m_zl;
    e.snd = (m_st == 1) || (m_st == 3);
    e.cl  = (m_st == 3);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    ack = 1'b0; clear = 1'b0; heat_in = 1'b0;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk("state", {30'd0, state}, {30'd0, e.st});
      chk("zone_latched", {28'd0, zone_latched}, {28'd0, e.zl});
      chk("sounder", {31'd0, sounder}, {31'd0, e.snd});
      chk("call", {31'd0, call}, {31'd0, e.cl});
    end
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    chk({tag, "_state"}, {30'd0, state}, 32'd0);
    chk({tag, "_zl"}, {28'd0, zone_latched}, 32'd0);
    chk({tag, "_snd"}, {31'd0, sounder}, 32'd0);
    chk({tag, "_call"}, {31'd0, call}, 32'd0);
    zone_in = 4'b0; heat_in = 1'b0; ack = 1'b0; clear = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_held_state"}, {30'd0, state}, 32'd0);
    reset = 1'b0;
    model_reset();
    sb_q.delete();
  endtask

  initial begin
    zone_in = 4'b0; heat_in = 1'b0; ack = 1'b0; clear = 1'b0; reset = 1'b0;
    model_reset();
    do_reset("por");

    // Glitch rejection: never four consecutive highs.
    for (int i = 0; i < 3; i++) cyc(4'b0001, 0, 0, 0);
    cyc(4'b0000, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(4'b0001, 0, 0, 0);
    cyc(4'b0000, 0, 0, 0);
    cyc(4'b0000, 0, 0, 0);
    chk("glitch_zl", {28'd0, zone_latched}, 32'd0);
    chk("glitch_state", {30'd0, state}, 32'd0);

    // Unacknowledged escalation.
    for (int i = 1; i <= 22; i++) begin
      cyc(4'b0001, 0, 0, 0);
      if (i == 4)  chk("esc_zl4", {28'd0, zone_latched}, 32'd1);
      if (i == 4)  chk("esc_snd4", {31'd0, sounder}, 32'd0);
      if (i == 5)  chk("esc_snd5", {31'd0, sounder}, 32'd1);
      if (i == 21) chk("esc_call21", {31'd0, call}, 32'd0);
      if (i == 22) chk("esc_call22", {31'd0, call}, 32'd1);
    end
    chk("esc_state", {30'd0, state}, 32'd3);
    cyc(4'b0001, 0, 0, 1);
    chk("esc_clear_busy", {30'd0, state}, 32'd3);
    cyc(4'b0000, 0, 0, 1);
    chk("esc_clear_state", {30'd0, state}, 32'd0);

    // Ack, resound, clear.
    do_reset("rst_ack");
    for (int i = 0; i < 5; i++) cyc(4'b0100, 0, 0, 0);
    cyc(4'b0000, 0, 0, 1);
    chk("alarm_clear_ign", {30'd0, state}, 32'd1);
    cyc(4'b0000, 0, 0, 0);
    cyc(4'b0000, 0, 1, 0);
    chk("ack_state", {30'd0, state}, 32'd2);
    chk("ack_snd", {31'd0, sounder}, 32'd0);
    for (int i = 1; i <= SC + 1; i++) begin
      cyc(4'b0000, 0, 0, 0);
      if (i == SC)     chk("silence_hold", {30'd0, state}, 32'd2);
      if (i == SC + 1) chk("resound", {31'd0, sounder}, 32'd1);
    end
    cyc(4'b0000, 0, 1, 0);
    cyc(4'b0000, 0, 0, 1);
    chk("acked_clear_state", {30'd0, state}, 32'd0);
    chk("acked_clear_zl", {28'd0, zone_latched}, 32'd0);

    // New zone during silence, then heat from ACKED.
    do_reset("rst_new");
    for (int i = 0; i < 5; i++) cyc(4'b0001, 0, 0, 0);
    cyc(4'b0000, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc(4'b1000, 0, 0, 0);
    chk("new_zone_state", {30'd0, state}, 32'd1);
    chk("new_zone_zl", {28'd0, zone_latched}, 32'h9);
    cyc(4'b0000, 0, 1, 0);
    cyc(4'b0000, 1, 0, 0);
    chk("acked_heat", {31'd0, call}, 32'd1);
    cyc(4'b0000, 0, 0, 1);

    // Priority: heat beats ack; clear ignored with zone or heat active.
    for (int i = 0; i < 5; i++) cyc(4'b0001, 0, 0, 0);
    cyc(4'b0000, 1, 1, 0);
    chk("heat_ack_state", {30'd0, state}, 32'd3);
    cyc(4'b0000, 0, 1, 0);
    cyc(4'b0001, 0, 0, 1);
    cyc(4'b0000, 1, 0, 1);
    chk("clear_ign_state", {30'd0, state}, 32'd3);
    cyc(4'b0000, 0, 0, 1);

    // Reset mid-alarm.
    for (int i = 0; i < 10; i++) cyc(4'b0010, 0, 0, 0);
    chk("pre_rst_state", {30'd0, state}, 32'd1);
    do_reset("rst_mid");
    cyc(4'b0000, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
